instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/mips_pkg.sv | 29 ++
 rtl/if_id_reg.sv | 27 ++
 rtl/instr_fetch.sv | 88 ++++++++
 tb/tb_instr_fetch.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: special instruction words,
// fetch FSM states and the IF/ID pipeline record.
package mips_pkg;

    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } if_id_t;

    // Sequential successor; wraps modulo 2^32 by construction.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: capture, hold on stall, or insert a bubble.
// A bubble clears valid/instr but leaves pc/pc4 untouched.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        stall,
    input  logic        bubble,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output if_id_t      stage
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= '{valid: 1'b0, instr: NOP, pc: 32'h0, pc4: 32'h0};
        end else if (bubble || !valid) begin
            stage.valid <= 1'b0;
            stage.instr <= NOP;
        end else if (!stall) begin
            stage <= '{valid: 1'b1, instr: instr, pc: pc, pc4: seq_pc(pc)};
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, RUN/HALTED control and the IF/ID
// register. Instruction memory is read combinationally at imem_addr.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc,
    output logic [31:0]       if_id_pc4,
    output logic              halted
);

    logic [31:0]  pc;
    fetch_state_e state;
    if_id_t       stage;
    logic         running;
    logic         capture;

    assign imem_addr = pc[ADDR_W+1:2];
    assign running   = (state == S_RUN);
    // A word is only really taken into IF/ID when nothing overrides the capture.
    assign capture   = running && !redirect_valid && !flush && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (capture && imem_data == HALT_WORD) begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                    end
                end
                S_HALTED: begin
                    state  <= S_HALTED;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= S_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    // Redirect beats stall; once halted only reset moves the PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (running) begin
            if (redirect_valid) begin
                pc <= align_word(redirect_pc);
            end else if (!stall) begin
                pc <= seq_pc(pc);
            end
        end
    end

    if_id_reg u_if_id (
        .clk    (clk),
        .rst    (rst),
        .valid  (running),
        .stall  (stall),
        .bubble (redirect_valid | flush),
        .instr  (imem_data),
        .pc     (pc),
        .stage  (stage)
    );

    assign if_id_valid = stage.valid;
    assign if_id_instr = stage.instr;
    assign if_id_pc    = stage.pc;
    assign if_id_pc4   = stage.pc4;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch against a cycle-level
// reference model of the fetch rules.
module tb_instr_fetch;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        if_id_valid, halted;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc4;

    logic [31:0] mem [256];

    int checks = 0;
    int passed = 0;

    // reference state
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
    logic        m_valid, m_halted;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .halted         (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock of the architectural rules, written from the behaviour:
    // what the pipeline should hold after the edge given these inputs.
    task automatic model(input logic r, input logic s, input logic f,
                         input logic rv, input logic [31:0] rpc);
        logic [31:0] word;
        if (r) begin
            m_pc = 32'h0; m_halted = 1'b0;
            m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
        end else if (m_halted) begin
            m_valid = 1'b0; m_instr = 32'h0;
        end else begin
            word = mem[m_pc[9:2]];
            if (rv || f) begin
                m_valid = 1'b0; m_instr = 32'h0;
            end else if (!s) begin
                m_valid = 1'b1; m_instr = word; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
                if (word == HALT) m_halted = 1'b1;
            end
            if (rv) m_pc = rpc & ~32'd3;
            else if (!s) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic f,
                        input logic rv, input logic [31:0] rpc);
        rst = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
        model(r, s, f, rv, rpc);
        @(posedge clk);
        #1;
        check("imem_addr", {24'h0, imem_addr}, {24'h0, m_pc[9:2]});
        check("valid",     {31'h0, if_id_valid}, {31'h0, m_valid});
        check("instr",     if_id_instr, m_instr);
        check("pc",        if_id_pc, m_ipc);
        check("pc4",       if_id_pc4, m_ipc4);
        check("halted",    {31'h0, halted}, {31'h0, m_halted});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic seq_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
    endtask

    initial begin
        seq_mem();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        m_pc = 32'hx; m_halted = 1'b0;

        // reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_addr",  {24'h0, imem_addr}, 32'h0);

        // sequential fetch, one-cycle latency
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("seq0_instr", if_id_instr, 32'h1000);
        check("seq0_addr",  {24'h0, imem_addr}, 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("seq1_pc", if_id_pc, 32'h4);

        // stall 3 cycles at pc=8
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            check("stall_addr", {24'h0, imem_addr}, 32'h2);
            check("stall_pc",   if_id_pc, 32'h4);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("resume_instr", if_id_instr, 32'h1002);

        // redirect with stall: unaligned target, one bubble
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h23);
        check("redir_bubble", {31'h0, if_id_valid}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("redir_pc", if_id_pc, 32'h20);

        // flush
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        run(2);

        // wrap at top of address space
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_pc",   if_id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4",  if_id_pc4, 32'h0);
        check("wrap_addr", {24'h0, imem_addr}, 32'h0);

        // HALT at word 5
        mem[5] = HALT;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        run(5);
        check("pre_halt", {31'h0, halted}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("halt_instr", if_id_instr, HALT);
        check("halt_flag",  {31'h0, halted}, 32'h1);
        check("halt_addr",  {24'h0, imem_addr}, 32'h6);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
        check("halt_bubble", {31'h0, if_id_valid}, 32'h0);
        check("halt_noredir", {24'h0, imem_addr}, 32'h6);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        run(2);

        // reset while halted
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rsth_halted", {31'h0, halted}, 32'h0);
        check("rsth_instr",  if_id_instr, 32'h0);
        check("rsth_pc",     if_id_pc, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rsth_first", if_id_instr, 32'h1000);

        // reset mid-stall
        run(2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h80);
        check("rsts_addr", {24'h0, imem_addr}, 32'h0);
        check("rsts_pc4",  if_id_pc4, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rsts_first", if_id_pc, 32'h0);

        // randomized traffic, occasional HALT words and resets
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 39) == 0) ? HALT : ($urandom & 32'h7FFF_FFFF);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
